fetch_pc_sequencer: RTL and testbench

- Fetch-stage PC owner. Consumes resolved jump targets (jal_addr/jalr_addr from the jump address calculator) and branch targets.
- Holds the architectural fetch PC and drives instruction-memory requests.
- Sequences redirects safely around in-flight imem accesses and flags misaligned targets to the exception logic.

---
 rtl/fetch_pc_sequencer_if.sv | 34 +++
 rtl/fetch_pc_sequencer.sv | 116 +++++++++++
 tb/tb_fetch_pc_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_sequencer_if.sv
// Fetch sequencer bus: redirect inputs, imem handshake and fetch/exception outputs.
// The sequencer takes the slave modport; the execute/imem side takes master.
interface fetch_pc_sequencer_if;
    logic        jump_valid;
    logic        jump_is_jalr;
    logic [31:0] jal_addr;
    logic [31:0] jalr_addr;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        stall;
    logic        imem_busy;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc4;
    logic        flush;
    logic        misaligned;
    logic [31:0] misaligned_addr;

    modport master (
        output jump_valid, jump_is_jalr, jal_addr, jalr_addr,
               branch_taken, branch_addr, stall, imem_busy,
        input  imem_ren, imem_addr, fetch_valid, fetch_pc, fetch_pc4,
               flush, misaligned, misaligned_addr
    );

    modport slave (
        input  jump_valid, jump_is_jalr, jal_addr, jalr_addr,
               branch_taken, branch_addr, stall, imem_busy,
        output imem_ren, imem_addr, fetch_valid, fetch_pc, fetch_pc4,
               flush, misaligned, misaligned_addr
    );
endinterface

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC owner: issues imem reads, applies jump/branch redirects (deferred while imem is busy).
// Latency: redirect visible on imem_addr 1 cycle later when idle, busy-duration + 1 otherwise.
module fetch_pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
    input logic                  CLK,
    input logic                  nRST,
    fetch_pc_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        RESET_HOLD       = 2'd0,
        FETCH            = 2'd1,
        REDIRECT_PENDING = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pending_q, pending_d;
    logic        mis_q, mis_d;
    logic [31:0] mis_addr_q, mis_addr_d;

    logic [31:0] target;
    logic        redirect_req;
    logic        target_misaligned;
    logic        redirect_ok;
    logic        complete;

    // Jump beats branch; JALR clears bit 0 of the raw sum.
    always_comb begin
        target = bus.branch_addr;
        if (bus.jump_valid) begin
            target = bus.jump_is_jalr ? (bus.jalr_addr & ~32'd1) : bus.jal_addr;
        end
    end

    assign redirect_req      = (bus.jump_valid | bus.branch_taken) && (state_q != RESET_HOLD);
    assign target_misaligned = |target[1:0];
    assign redirect_ok       = redirect_req & ~target_misaligned;
    assign complete          = ~bus.stall & ~bus.imem_busy;

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        pending_d       = pending_q;
        mis_d           = 1'b0;
        mis_addr_d      = mis_addr_q;
        bus.imem_ren    = 1'b0;
        bus.fetch_valid = 1'b0;
        bus.flush       = 1'b0;

        if (redirect_req && target_misaligned) begin
            mis_d      = 1'b1;
            mis_addr_d = target;
        end

        case (state_q)
            RESET_HOLD: begin
                state_d = FETCH;
            end
            FETCH: begin
                bus.imem_ren = ~bus.stall;
                if (redirect_ok) begin
                    bus.flush = 1'b1;
                    if (bus.imem_busy) begin
                        pending_d = target;
                        state_d   = REDIRECT_PENDING;
                    end else begin
                        pc_d = target;
                    end
                end else if (!(redirect_req && target_misaligned) && complete) begin
                    // A faulting redirect holds pc, so that cycle's response is re-fetched.
                    bus.fetch_valid = 1'b1;
                    pc_d            = pc_q + 32'd4;
                end
            end
            REDIRECT_PENDING: begin
                bus.imem_ren = 1'b1;
                if (redirect_ok) begin
                    bus.flush = 1'b1;
                    pending_d = target;
                end
                if (!bus.imem_busy) begin
                    pc_d    = redirect_ok ? target : pending_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = RESET_HOLD;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= RESET_HOLD;
            pc_q       <= RESET_PC;
            pending_q  <= 32'd0;
            mis_q      <= 1'b0;
            mis_addr_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pending_q  <= pending_d;
            mis_q      <= mis_d;
            mis_addr_q <= mis_addr_d;
        end
    end

    assign bus.imem_addr       = pc_q;
    assign bus.fetch_pc        = pc_q;
    assign bus.fetch_pc4       = pc_q + 32'd4;
    assign bus.misaligned      = mis_q;
    assign bus.misaligned_addr = mis_addr_q;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed vector bench for fetch_pc_sequencer: one table row per cycle plus an async-reset sequence.
module tb_fetch_pc_sequencer;

    logic CLK;
    logic nRST;
    int   n_tests;
    int   n_fail;

    fetch_pc_sequencer_if bus_if ();

    fetch_pc_sequencer #(.RESET_PC(32'h0000_0200)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus_if)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        jv;
        logic        jr;
        logic [31:0] jal;
        logic [31:0] jalr;
        logic        bt;
        logic [31:0] ba;
        logic        st;
        logic        bz;
        logic        e_ren;
        logic [31:0] e_addr;
        logic        e_fv;
        logic [31:0] e_pc4;
        logic        e_fl;
        logic        e_mis;
        logic [31:0] e_maddr;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic jv, logic jr, logic [31:0] jal, logic [31:0] jalr,
                                logic bt, logic [31:0] ba, logic st, logic bz,
                                logic e_ren, logic [31:0] e_addr, logic e_fv,
                                logic [31:0] e_pc4, logic e_fl, logic e_mis,
                                logic [31:0] e_maddr);
        vec_t v;
        v.jv = jv; v.jr = jr; v.jal = jal; v.jalr = jalr;
        v.bt = bt; v.ba = ba; v.st = st; v.bz = bz;
        v.e_ren = e_ren; v.e_addr = e_addr; v.e_fv = e_fv; v.e_pc4 = e_pc4;
        v.e_fl = e_fl; v.e_mis = e_mis; v.e_maddr = e_maddr;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        bus_if.jump_valid   = v.jv;
        bus_if.jump_is_jalr = v.jr;
        bus_if.jal_addr     = v.jal;
        bus_if.jalr_addr    = v.jalr;
        bus_if.branch_taken = v.bt;
        bus_if.branch_addr  = v.ba;
        bus_if.stall        = v.st;
        bus_if.imem_busy    = v.bz;
    endtask

    task automatic check_vec(string tag, vec_t v);
        chk({tag, ".imem_ren"},        {31'd0, bus_if.imem_ren},    {31'd0, v.e_ren});
        chk({tag, ".imem_addr"},       bus_if.imem_addr,            v.e_addr);
        chk({tag, ".fetch_pc"},        bus_if.fetch_pc,             v.e_addr);
        chk({tag, ".fetch_valid"},     {31'd0, bus_if.fetch_valid}, {31'd0, v.e_fv});
        chk({tag, ".fetch_pc4"},       bus_if.fetch_pc4,            v.e_pc4);
        chk({tag, ".flush"},           {31'd0, bus_if.flush},       {31'd0, v.e_fl});
        chk({tag, ".misaligned"},      {31'd0, bus_if.misaligned},  {31'd0, v.e_mis});
        chk({tag, ".misaligned_addr"}, bus_if.misaligned_addr,      v.e_maddr);
    endtask

    localparam logic [31:0] Z = 32'd0;

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Row = inputs applied this cycle, outputs expected in the same cycle.
        //            jv jr jal          jalr         bt ba           st bz  ren addr          fv pc4           fl mis maddr
        vq.push_back(mk(1, 0, 32'h900,     Z,           0, Z,           0, 0,  0, 32'h200,      0, 32'h204,      0, 0, Z));        // RESET_HOLD ignores jump
        vq.push_back(mk(0, 0, Z,           Z,           0, Z,           0, 0,  1, 32'h200,      1, 32'h204,      0, 0, Z));
        vq.push_back(mk(0, 0, Z,           Z,           0, Z,           0, 0,  1, 32'h204,      1, 32'h208,      0, 0, Z));
        vq.push_back(mk(0, 0, Z,           Z,           0, Z,           0, 0,  1, 32'h208,      1, 32'h20C,      0, 0, Z));
        vq.push_back(mk(0, 0, Z,           Z,           0, Z,           1, 0,  0, 32'h20C,      0, 32'h210,      0, 0, Z));        // stall holds pc
        vq.push_back(mk(0, 0, Z,           Z,           0, Z,           0, 0,  1, 32'h20C,      1, 32'h210,      0, 0, Z));
        vq.push_back(mk(1, 1, Z,           32'h1003,    0, Z,           0, 0,  1, 32'h210,      0, 32'h214,      0, 0, Z));        // jalr -> 0x1002 misaligned
        vq.push_back(mk(0, 0, Z,           Z,           0, Z,           0, 0,  1, 32'h210,      1, 32'h214,      0, 1, 32'h1002));
        vq.push_back(mk(1, 1, Z,           32'h1001,    0, Z,           0, 0,  1, 32'h214,      0, 32'h218,      1, 0, 32'h1002)); // jalr -> 0x1000
        vq.push_back(mk(0, 0, Z,           Z,           0, Z,           0, 0,  1, 32'h1000,     1, 32'h1004,     0, 0, 32'h1002));
        vq.push_back(mk(1, 0, 32'h300,     Z,           0, Z,           0, 0,  1, 32'h1004,     0, 32'h1008,     1, 0, 32'h1002));
        vq.push_back(mk(0, 0, Z,           Z,           1, 32'h400,     0, 1,  1, 32'h300,      0, 32'h304,      1, 0, 32'h1002)); // branch while busy
        vq.push_back(mk(0, 0, Z,           Z,           0, Z,           0, 1,  1, 32'h300,      0, 32'h304,      0, 0, 32'h1002));
        vq.push_back(mk(0, 0, Z,           Z,           0, Z,           0, 1,  1, 32'h300,      0, 32'h304,      0, 0, 32'h1002));
        vq.push_back(mk(0, 0, Z,           Z,           0, Z,           0, 0,  1, 32'h300,      0, 32'h304,      0, 0, 32'h1002)); // response discarded
        vq.push_back(mk(0, 0, Z,           Z,           0, Z,           0, 0,  1, 32'h400,      1, 32'h404,      0, 0, 32'h1002));
        vq.push_back(mk(1, 0, 32'h800,     Z,           1, 32'h900,     0, 0,  1, 32'h404,      0, 32'h408,      1, 0, 32'h1002)); // jump beats branch
        vq.push_back(mk(0, 0, Z,           Z,           0, Z,           0, 0,  1, 32'h800,      1, 32'h804,      0, 0, 32'h1002));
        vq.push_back(mk(1, 0, 32'hFFFFFFFC, Z,          0, Z,           0, 0,  1, 32'h804,      0, 32'h808,      1, 0, 32'h1002));
        vq.push_back(mk(0, 0, Z,           Z,           0, Z,           0, 0,  1, 32'hFFFFFFFC, 1, 32'h0,        0, 0, 32'h1002)); // wrap
        vq.push_back(mk(0, 0, Z,           Z,           0, Z,           0, 0,  1, 32'h0,        1, 32'h4,        0, 0, 32'h1002));
        vq.push_back(mk(1, 0, 32'h600,     Z,           0, Z,           0, 1,  1, 32'h4,        0, 32'h8,        1, 0, 32'h1002));
        vq.push_back(mk(0, 0, Z,           Z,           1, 32'h702,     0, 1,  1, 32'h4,        0, 32'h8,        0, 0, 32'h1002)); // misaligned in pending
        vq.push_back(mk(1, 0, 32'h640,     Z,           0, Z,           0, 1,  1, 32'h4,        0, 32'h8,        1, 1, 32'h702));  // overwrite pending
        vq.push_back(mk(0, 0, Z,           Z,           0, Z,           0, 0,  1, 32'h4,        0, 32'h8,        0, 0, 32'h702));
        vq.push_back(mk(0, 0, Z,           Z,           0, Z,           0, 0,  1, 32'h640,      1, 32'h644,      0, 0, 32'h702));
        vq.push_back(mk(1, 0, 32'h700,     Z,           0, Z,           1, 0,  0, 32'h644,      0, 32'h648,      1, 0, 32'h702));  // redirect ignores stall
        vq.push_back(mk(0, 0, Z,           Z,           0, Z,           0, 0,  1, 32'h700,      1, 32'h704,      0, 0, 32'h702));

        nRST = 1'b0;
        drive(mk(0, 0, Z, Z, 0, Z, 0, 0, 0, Z, 0, Z, 0, 0, Z));
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_vec("reset", mk(0, 0, Z, Z, 0, Z, 0, 0, 0, 32'h200, 0, 32'h204, 0, 0, Z));

        @(posedge CLK);
        #1;
        nRST = 1'b1;
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i]);
            @(negedge CLK);
            check_vec($sformatf("v%0d", i), vq[i]);
            @(posedge CLK);
            #1;
        end

        // Async reset in the middle of a pending redirect to 0x500.
        drive(mk(1, 0, 32'h500, Z, 0, Z, 0, 1, 0, Z, 0, Z, 0, 0, Z));
        @(negedge CLK);
        chk("rp.flush", {31'd0, bus_if.flush}, 32'd1);
        @(posedge CLK);
        #1;
        drive(mk(0, 0, Z, Z, 0, Z, 0, 1, 0, Z, 0, Z, 0, 0, Z));
        @(negedge CLK);
        chk("rp.pending_ren", {31'd0, bus_if.imem_ren}, 32'd1);
        chk("rp.pending_addr", bus_if.imem_addr, 32'h704);
        #2;
        nRST = 1'b0;
        #1;
        chk("rp.rst_ren",   {31'd0, bus_if.imem_ren}, 32'd0);
        chk("rp.rst_addr",  bus_if.imem_addr, 32'h200);
        chk("rp.rst_maddr", bus_if.misaligned_addr, 32'd0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        drive(mk(0, 0, Z, Z, 0, Z, 0, 0, 0, Z, 0, Z, 0, 0, Z));
        @(negedge CLK);
        check_vec("rp.hold", mk(0, 0, Z, Z, 0, Z, 0, 0, 0, 32'h200, 0, 32'h204, 0, 0, Z));
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check_vec("rp.f0", mk(0, 0, Z, Z, 0, Z, 0, 0, 1, 32'h200, 1, 32'h204, 0, 0, Z));
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check_vec("rp.f1", mk(0, 0, Z, Z, 0, Z, 0, 0, 1, 32'h204, 1, 32'h208, 0, 0, Z));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
